// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioning block.
package btn_pkg;

    typedef enum logic [1:0] {IDLE, CHK_HI, HELD, CHK_LO} btn_state_t;

    localparam int CLK_HZ      = 100_000_000;
    localparam int DEBOUNCE_MS = 10;

    // Default debounce window in clock cycles (10 ms at 100 MHz).
    localparam int DEFAULT_STABLE = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button channel bundle: raw pad in, debounced level and press/release pulses out.
interface btn_conditioner_if #(
    parameter int W = 1
);
    logic [W-1:0] btn;
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rel;

    modport master (output btn, input level, press, rel);
    modport slave  (input btn, output level, press, rel);
endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and stability counter.
// Auto-repeat of press pulses is built when BTN_CONDITIONER_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    btn_conditioner_if.slave   ch
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync_p0, r_sync_p1;
    btn_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_level, w_level_nxt;
    logic             r_press, w_press_nxt;
    logic             r_rel, w_rel_nxt;
    logic             w_s;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = $clog2(RMAX + 1);
    localparam logic [RCNT_W-1:0] R_DLY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] R_PER_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic [RCNT_W-1:0] r_rcnt, w_rcnt_nxt;
    logic              r_rep_phase, w_rep_phase_nxt;
    logic [RCNT_W-1:0] w_rep_last;

    assign w_rep_last = r_rep_phase ? R_PER_LAST : R_DLY_LAST;
`endif

    assign w_s = r_sync_p1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_press_nxt = 1'b0;
        w_rel_nxt   = 1'b0;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        w_rcnt_nxt      = r_rcnt;
        w_rep_phase_nxt = r_rep_phase;
`endif
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = HELD;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_state_nxt = CHK_HI;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            CHK_HI: begin
                if (!w_s) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_LAST) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_s) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = IDLE;
                        w_level_nxt = 1'b0;
                        w_rel_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = CHK_LO;
                        w_cnt_nxt   = CNT_W'(1);
                    end
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
                end else if (r_rcnt == w_rep_last) begin
                    w_press_nxt     = 1'b1;
                    w_rcnt_nxt      = '0;
                    w_rep_phase_nxt = 1'b1;
                end else begin
                    w_rcnt_nxt      = r_rcnt + 1'b1;
`endif
                end
            end
            CHK_LO: begin
                if (w_s) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_rel_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        // Repeat timing survives a brief dip into CHK_LO but restarts on any fresh press.
        if (w_state_nxt == IDLE || w_state_nxt == CHK_HI) begin
            w_rcnt_nxt      = '0;
            w_rep_phase_nxt = 1'b0;
        end
`endif
    end

    // Stage p0/p1: pad synchroniser; FSM state and registered outputs follow.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_rel     <= 1'b0;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
            r_rcnt      <= '0;
            r_rep_phase <= 1'b0;
`endif
        end else begin
            r_sync_p0 <= ch.btn;
            r_sync_p1 <= r_sync_p0;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_rel     <= w_rel_nxt;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
            r_rcnt      <= w_rcnt_nxt;
            r_rep_phase <= w_rep_phase_nxt;
`endif
        end
    end

    assign ch.level = r_level;
    assign ch.press = r_press;
    assign ch.rel   = r_rel;

endmodule

// File: rtl/btn_conditioner.sv
// N independent debounced button channels with level and press/release pulses.
// Optional auto-repeat: define BTN_CONDITIONER_AUTOREPEAT_EN.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N             = 5,
    parameter int STABLE_CYCLES = DEFAULT_STABLE,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1),
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] btn_i,
    output logic [N-1:0] level_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o
);

    if (STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_conditioner: timing parameters must be >= 1");
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        btn_conditioner_if #(.W(1)) u_if ();

        assign u_if.btn     = btn_i[g];
        assign level_o[g]   = u_if.level;
        assign press_o[g]   = u_if.press;
        assign release_o[g] = u_if.rel;

        btn_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .ch    (u_if.slave)
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: run-length debounce model checked every cycle plus directed literal checks.
module tb_btn_conditioner;

    localparam int N  = 5;
    localparam int S  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    btn_conditioner_if #(.W(N)) tb_if ();

    always #5 clk = ~clk;

    btn_conditioner #(
        .N             (N),
        .STABLE_CYCLES (S),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .btn_i     (tb_if.btn),
        .level_o   (tb_if.level),
        .press_o   (tb_if.press),
        .release_o (tb_if.rel)
    );

    // Model: a new level is accepted after S consecutive synchronised samples that differ from it.
    logic [N-1:0] m_d1 = '0, m_d2 = '0, m_level = '0, m_press = '0, m_rel = '0;
    int m_run [N];
    int m_rep [N];

    task automatic model_step();
        logic x;
        if (!rst_n) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < N; i++) begin m_run[i] = 0; m_rep[i] = 0; end
        end else begin
            for (int i = 0; i < N; i++) begin
                x = m_d2[i];
                m_press[i] = 1'b0;
                m_rel[i]   = 1'b0;
                if (x != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == S) begin
                        m_level[i] = x;
                        m_run[i]   = 0;
                        m_rep[i]   = 0;
                        if (x) m_press[i] = 1'b1;
                        else   m_rel[i]   = 1'b1;
                    end
                end else begin
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
                    if (m_level[i] && m_run[i] == 0) begin
                        m_rep[i]++;
                        if (m_rep[i] == RD || (m_rep[i] > RD && (m_rep[i] - RD) % RP == 0))
                            m_press[i] = 1'b1;
                    end
`endif
                    m_run[i] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = tb_if.btn;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin m_run[i] = 0; m_rep[i] = 0; end
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            total++;
            if (tb_if.level !== m_level || tb_if.press !== m_press || tb_if.rel !== m_rel) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t level got %b want %b, press got %b want %b, release got %b want %b",
                         $time, tb_if.level, m_level, tb_if.press, m_press, tb_if.rel, m_rel);
            end
            total++;
            if ((tb_if.press & tb_if.rel) !== '0) begin
                bad++;
                $display("FAIL press_and_release t=%0t press=%b release=%b want no overlap",
                         $time, tb_if.press, tb_if.rel);
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp;
        tb_if.btn = '0;
        rst_n = 1'b0;
        tick(3);
        chk("reset_level", tb_if.level, '0);
        chk("reset_press", tb_if.press, '0);
        chk("reset_release", tb_if.rel, '0);
        rst_n = 1'b1;
        tick(2);

        // Clean press and release on channel 0.
        tb_if.btn[0] = 1'b1;
        tick(5);
        chk("press0_e5", tb_if.press, 5'b00000);
        chk("level0_e5", tb_if.level, 5'b00000);
        tick(1);
        chk("press0_e6", tb_if.press, 5'b00001);
        chk("level0_e6", tb_if.level, 5'b00001);
        tick(1);
        chk("press0_e7", tb_if.press, 5'b00000);
        chk("level0_e7", tb_if.level, 5'b00001);
        tick(3);
        tb_if.btn[0] = 1'b0;
        tick(5);
        chk("rel0_e5", tb_if.rel, 5'b00000);
        tick(1);
        chk("rel0_e6", tb_if.rel, 5'b00001);
        chk("level0_rel", tb_if.level, 5'b00000);
        tick(1);
        chk("rel0_e7", tb_if.rel, 5'b00000);

        // Bounce on channel 1.
        tb_if.btn[1] = 1'b1; tick(1);
        tb_if.btn[1] = 1'b0; tick(1);
        tb_if.btn[1] = 1'b1; tick(1);
        tb_if.btn[1] = 1'b0; tick(1);
        tb_if.btn[1] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            chk("bounce_quiet", tb_if.press | tb_if.level | tb_if.rel, 5'b00000);
        end
        tick(1);
        chk("bounce_press", tb_if.press, 5'b00010);
        tick(1);
        chk("bounce_single", tb_if.press, 5'b00000);
        tb_if.btn[1] = 1'b0;
        tick(8);

        // Short glitch on channel 2.
        tb_if.btn[2] = 1'b1;
        tick(3);
        tb_if.btn[2] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            chk("glitch_quiet", tb_if.press | tb_if.level | tb_if.rel, 5'b00000);
        end

        // Simultaneous press and release.
        tb_if.btn = 5'b10101;
        tick(6);
        chk("simul_press", tb_if.press, 5'b10101);
        chk("simul_level", tb_if.level, 5'b10101);
        tick(1);
        chk("simul_press_end", tb_if.press, 5'b00000);
        tb_if.btn = 5'b00000;
        tick(6);
        chk("simul_release", tb_if.rel, 5'b10101);
        chk("simul_level_off", tb_if.level, 5'b00000);
        tick(2);

        // Reset while channel 3 is held.
        tb_if.btn[3] = 1'b1;
        tick(8);
        chk("hold3_level", tb_if.level, 5'b01000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_level", tb_if.level, 5'b00000);
        chk("rst_async_press", tb_if.press | tb_if.rel, 5'b00000);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("repress3_e5", tb_if.press, 5'b00000);
        tick(1);
        chk("repress3_e6", tb_if.press, 5'b01000);
        chk("repress3_level", tb_if.level, 5'b01000);
        tb_if.btn[3] = 1'b0;
        tick(8);

        // Long hold on channel 4: auto-repeat only in the macro build.
        tb_if.btn[4] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick(1);
            exp = (e == 6) ? 5'b10000 : 5'b00000;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
            if (e == 14 || e == 17 || e == 20) exp = 5'b10000;
`endif
            chk("hold4_press", tb_if.press, exp);
        end
        tb_if.btn[4] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            chk("rel4_press", tb_if.press, 5'b00000);
            chk("rel4_release", tb_if.rel, (e == 6) ? 5'b10000 : 5'b00000);
        end

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end input-conditioning stage for the board's push-buttons.
- Per channel: synchronises the raw pad, debounces it, and produces a clean level plus single-cycle press/release pulses.
- Its outputs drive the rst/cnt/wr/rd/ev command inputs of the control logic stage, so each pulse is exactly one clk_i cycle wide.

Parameters:
- N, 5, number of independent button channels (U, D, L, R, C).
- STABLE_CYCLES, 1_000_000, consecutive cycles a changed input must hold before it is accepted (10 ms at 100 MHz); must be >= 1.
- CNT_W, $clog2(STABLE_CYCLES+1), stability-counter width.
- REPEAT_DELAY, 50_000_000, cycles held before the first auto-repeat (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 10_000_000, cycles between subsequent auto-repeats (AUTOREPEAT_EN only).

Ports:
- clk_i  in  1  system clock, 100 MHz.
- rst_i  in  1  asynchronous, active-low reset.
- btn_i  in  N  raw, asynchronous button pads.
- level_o  out  N  debounced level.
- press_o  out  N  one-cycle pulse on accepted 0->1.
- release_o  out  N  one-cycle pulse on accepted 1->0.

Behaviour:
- Reset (rst_i=0, asynchronous): sync flops, counters, level_o, press_o and release_o are all 0; FSM goes to IDLE. Release of reset is sampled synchronously.
- Synchroniser: two-flop chain per channel; s = second flop.
- FSM per channel:
  - IDLE (level 0): s=1 -> CHK_HI with cnt=1.
  - CHK_HI: s=0 -> IDLE, cnt=0. s=1 with cnt==STABLE_CYCLES-1 -> HELD, level_o<=1, press_o<=1. Otherwise cnt++.
  - HELD (level 1): s=0 -> CHK_LO with cnt=1.
  - CHK_LO: s=1 -> HELD, cnt=0. s=0 with cnt==STABLE_CYCLES-1 -> IDLE, level_o<=0, release_o<=1. Otherwise cnt++.
- STABLE_CYCLES=1: transition is immediate on the first differing s sample; no CHK state is entered.
- Latency:
  - level_o and press_o assert on edge STABLE_CYCLES+2, where edge 1 is the first edge that samples btn_i=1 and btn_i is held.
  - Release is symmetric.
- Pulses:
  - press_o/release_o are registered and high for exactly one cycle.
  - press_o and release_o are never high together on one channel.
  - A press followed later by a release always yields exactly one of each.
- Glitch rejection: a single sample of s equal to the current level restarts the count from 0. Bursts shorter than STABLE_CYCLES produce no output change.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses.
- Counter saturation: cnt never exceeds STABLE_CYCLES-1; no wrap.
- Reset mid-count or mid-hold: all state is discarded. A button still held after reset is re-debounced and produces a fresh press_o.

Optional Feature:
- Macro: BTN_CONDITIONER_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs.
  - After REPEAT_DELAY cycles from the press_o cycle, press_o pulses again, then every REPEAT_PERIOD cycles while HELD.
  - Leaving HELD clears the repeat counter. Entering CHK_LO freezes it, and a return to HELD resumes it.
- Undefined: no repeat logic, parameters unused, exactly one press_o per accepted press.

Decomposition:
- Package btn_pkg holds:
  - typedef enum logic [1:0] btn_state_t {IDLE, CHK_HI, HELD, CHK_LO};
  - default-timing localparams (CLK_HZ=100_000_000, DEBOUNCE_MS=10).
- Sub-module btn_channel: one synchroniser + FSM + counter (+ repeat counter).
- btn_conditioner instantiates N of these in a generate loop.

Test Plan (STABLE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
- Clean press: btn_i[0] 0->1 held -> level_o[0]=1 and press_o[0]=1 for one cycle at edge 6; release held -> release_o[0] one cycle, 6 edges after release.
- Bounce: btn_i[1] toggles 1,0,1,0 each cycle then holds 1 -> exactly one press_o[1], 6 edges after the final rise; no pulses during the bounce.
- Short glitch: btn_i[2] high for 3 cycles -> level_o, press_o and release_o stay 0.
- Simultaneous: btn_i=5'b10101 in one cycle -> press_o=5'b10101 on the same edge, others 0.
- Reset mid-hold: rst_i=0 while level_o[3]=1 -> all outputs 0 immediately. Release reset with btn held -> new press_o[3] 6 edges later.
- Auto-repeat (macro defined): hold btn_i[4] -> press_o[4] at edges 6, 14, 17, 20; release -> pulses stop, one release_o.
